// File: rtl/linear_image_filter_sdiv_seq.sv
// linear_image_filter_sdiv_seq
//
// Multi-cycle signed integer divider that normalises accumulated convolution
// sums. One dividend/divisor pair is accepted per start handshake. A radix-2
// restoring iteration runs over the operand magnitudes, and a final fix-up
// edge applies the signs. Quotient truncates toward zero and the remainder
// takes the dividend's sign. Latency is WIDTH+2 ce-enabled edges from accept
// to done.
//
// Ports:
//   clk_i          rising-edge clock
//   reset_i        synchronous active-high reset, overrides ce_i
//   ce_i           clock enable; when low every register holds
//   start_i        request, accepted when ce_i && start_i && ready_o
//   din0_i         signed dividend, sampled on the accept edge
//   din1_i         signed divisor, sampled on the accept edge
//   ready_o        high while idle
//   done_o         one ce-enabled cycle pulse when results update
//   quot_o         signed quotient, held until the next done
//   rem_o          signed remainder, held until the next done
//   div_by_zero_o  qualifies quot_o/rem_o, held with them
module linear_image_filter_sdiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ce_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] din0_i,
  input  logic [WIDTH-1:0] din1_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d;       // quotient sign
  logic             neg_r_q, neg_r_d;       // remainder sign (dividend sign)
  logic             zero_q, zero_d;         // divisor was zero
  logic [WIDTH-1:0] orig_q, orig_d;         // original dividend for div-by-zero
  logic [WIDTH-1:0] dvd_q, dvd_d;           // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;           // divisor magnitude
  logic [WIDTH:0]   prem_q, prem_d;         // partial remainder
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] mag0, mag1;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rmag;

  // |MIN| wraps to MIN, which is the correct unsigned magnitude 2^(WIDTH-1).
  assign mag0 = din0_i[WIDTH-1] ? -din0_i : din0_i;
  assign mag1 = din1_i[WIDTH-1] ? -din1_i : din1_i;

  assign accept  = start_i && (state_q == StIdle);
  assign shifted = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign rmag    = prem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    zero_d  = zero_q;
    orig_d  = orig_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    // done is a single enabled-cycle pulse following the FIX edge.
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          cnt_d   = '0;
          neg_q_d = din0_i[WIDTH-1] ^ din1_i[WIDTH-1];
          neg_r_d = din0_i[WIDTH-1];
          zero_d  = (din1_i == '0);
          orig_d  = din0_i;
          dvd_d   = mag0;
          dvs_d   = mag1;
          prem_d  = '0;
        end
      end
      StRun: begin
        // Negative trial result (top bit set) means the subtraction is undone.
        if (!trial[WIDTH]) begin
          prem_d = trial;
        end else begin
          prem_d = shifted;
        end
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = orig_q;
          dbz_d  = 1'b1;
        end else begin
          // MIN / -1 falls out naturally: negating 2^(WIDTH-1) wraps to MIN.
          quot_d = neg_q_q ? -dvd_q : dvd_q;
          rem_d  = neg_r_q ? -rmag : rmag;
          dbz_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      orig_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (ce_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      zero_q  <= zero_d;
      orig_q  <= orig_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign ready_o       = (state_q == StIdle);
  assign done_o        = done_q;
  assign quot_o        = quot_q;
  assign rem_o         = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_linear_image_filter_sdiv_seq.sv
// Self-checking bench for linear_image_filter_sdiv_seq at WIDTH=32.
// Expected results are queued when a request is accepted and popped on done.
module tb_linear_image_filter_sdiv_seq;

  localparam int W = 32;
  localparam int Lat = W + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         ce;
  logic         start;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         ready;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  linear_image_filter_sdiv_seq #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .ce_i         (ce),
    .start_i      (start),
    .din0_i       (din0),
    .din1_i       (din1),
    .ready_o      (ready),
    .done_o       (done),
    .quot_o       (quot),
    .rem_o        (rem),
    .div_by_zero_o(div_by_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else if (a == 32'sh8000_0000 && b == -1) begin
      e.q = a;
      e.r = '0;
      e.z = 1'b0;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    return e;
  endfunction

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_spurious_done"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quot"}, quot, e.q);
      chk({tag, "_rem"}, rem, e.r);
      chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.z});
      chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    end
  endtask

  // Accept one request, then wait (bounded) for done and check latency/results.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    int edges;
    chk({tag, "_ready_pre"}, {31'd0, ready}, 32'd1);
    sb.push_back(mk(q, r, z));
    din0  = a;
    din1  = b;
    start = 1'b1;
    tick();
    edges = 1;
    start = 1'b0;
    din0  = $urandom;
    din1  = $urandom;
    while (!done && edges < 200) begin
      tick();
      edges++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      chk({tag, "_latency"}, edges, Lat);
      check_result(tag);
    end
  endtask

  initial begin
    int last_done;
    int edges;
    int cnt;
    logic [W-1:0] held_q;

    reset = 1'b1;
    ce    = 1'b0;  // reset must act regardless of ce
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    tick();
    tick();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    ce    = 1'b1;
    tick();

    // Sign quadrants
    do_op("pp", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    do_op("np", -32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0);
    do_op("pn", 32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0);
    do_op("nn", -32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0);

    // Extremes
    do_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    do_op("min_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
    do_op("small_max", 32'd7, 32'h7FFF_FFFF, 32'd0, 32'd7, 1'b0);

    // Divide by zero, then a normal request clears the flag
    do_op("dbz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    do_op("after_dbz", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Handshake: start held high with operands changing every cycle
    tick();
    chk("hs_done_clear", {31'd0, done}, 32'd0);
    start     = 1'b1;
    last_done = -1;
    for (int i = 0; i < 120; i++) begin
      if (done) begin
        check_result("hs");
        if (last_done >= 0) chk("hs_spacing", i - last_done, Lat);
        last_done = i;
      end
      din0 = $urandom;
      din1 = $urandom_range(1000, 1);
      if (ready) sb.push_back(model(din0, din1));
      tick();
    end
    start = 1'b0;
    cnt   = 0;
    while (sb.size() != 0 && cnt < 60) begin
      if (done) check_result("hs_drain");
      else begin
        tick();
        cnt++;
      end
    end
    chk("hs_drained", sb.size(), 32'd0);

    // Stall: 5 ce-low cycles in RUN, 3 during the done cycle
    tick();
    sb.push_back(mk(32'd14, 32'd2, 1'b0));
    din0  = 32'd100;
    din1  = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    while (!done && edges < 200) begin
      ce = (edges >= 10 && edges < 15) ? 1'b0 : 1'b1;
      tick();
      edges++;
    end
    ce = 1'b1;
    chk("stall_latency", edges, Lat + 5);
    held_q = quot;
    check_result("stall");
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_done_held", {31'd0, done}, 32'd1);
      chk("stall_quot_held", quot, held_q);
    end
    ce = 1'b1;
    tick();
    chk("stall_done_drop", {31'd0, done}, 32'd0);

    // Reset mid-RUN; coincident start must be dropped
    din0  = -32'sd1000;
    din1  = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    start = 1'b1;
    din0  = 32'd50;
    din1  = 32'd5;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quot", quot, 32'd0);
    chk("abort_rem", rem, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 32'd0);
    do_op("post_abort", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
